// File: rtl/lsu.sv
// Load/store unit: single-outstanding initiator to the data memory.
// Byte stores are done as read-modify-write since the memory has no byte enables.
// Optional feature macro: LSU_ALIGN_CHECK_EN rejects unaligned and out-of-range
// accesses with resp_err; when undefined, addresses alias and resp_err is 0.
module lsu #(
    parameter int n = 16,
    parameter int r = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic         req_byte,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    output logic         mem_write,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata
);

    if (n < 16 || r + 2 > n) begin : g_bad_params
        $error("lsu: need n >= 16 and r + 2 <= n");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] addr_q, addr_d;
    logic [n-1:0] wdata_q, wdata_d;
    logic [n-1:0] rdata_q, rdata_d;
    logic [n-1:0] merge_q, merge_d;
    logic         write_q, write_d;
    logic         byte_q, byte_d;
    logic         accept;
    logic [n-1:0] merged;

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q, err_d;
    logic req_bad;

    // Reject unaligned word/byte accesses and addresses beyond memory depth
    always_comb begin
        req_bad = 1'b0;
        if (!req_byte && (req_addr[1:0] != 2'b00)) req_bad = 1'b1;
        if (req_byte && req_addr[1]) req_bad = 1'b1;
        if ((req_addr >> (r + 2)) != '0) req_bad = 1'b1;
    end
`endif

    assign accept = req_valid && (state_q == IDLE);

    // Replace the selected byte lane of the read-back word with the store byte
    always_comb begin
        merged = merge_q;
        if (addr_q[0]) merged[15:8] = wdata_q[7:0];
        else           merged[7:0]  = wdata_q[7:0];
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        write_d = write_q;
        byte_d  = byte_q;
`ifdef LSU_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    byte_d  = req_byte;
                    rdata_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
                    err_d   = req_bad;
                    if (req_bad)        state_d = RESP;
                    else
`endif
                    if (!req_write)     state_d = LOAD;
                    else if (!req_byte) state_d = STORE;
                    else                state_d = RMW_RD;
                end
            end
            LOAD: begin
                if (byte_q) rdata_d = n'(addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]);
                else        rdata_d = mem_rdata;
                state_d = RESP;
            end
            STORE:  state_d = RESP;
            RMW_RD: begin
                merge_d = mem_rdata;
                state_d = RMW_WR;
            end
            RMW_WR: state_d = RESP;
            RESP:   if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            write_q <= write_d;
            byte_q  <= byte_d;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decoded from state and latched request
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        mem_write  = (state_q == STORE) || (state_q == RMW_WR);
        mem_addr   = addr_q;
        mem_wdata  = (state_q == RMW_WR) ? merged : wdata_q;
        resp_rdata = write_q ? '0 : rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
        resp_err   = err_q;
`else
        resp_err   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a 32-word combinational-read memory model.
module tb_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [32];
    int          wr_cnt = 0;
    int          n_pass = 0;
    int          n_checks = 0;
    int          lat;
    int          wr_before;

    lsu #(.n(16), .r(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[6:2]];

    always @(posedge clock) begin
        if (mem_write) begin
            mem[mem_addr[6:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request with resp_ready high; check latency, data, error
    task automatic do_req(input string tag, input logic w, input logic b,
                          input logic [15:0] a, input logic [15:0] d,
                          input int exp_lat, input logic [15:0] exp_rdata,
                          input logic exp_err);
        check({tag, "_ready"}, req_ready, 1'b1);
        req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, resp_err, exp_err);
        tick();
        check({tag, "_idle"}, req_ready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        mem[1] = 16'hAABB;

        // Reset values
        tick(); tick();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 16'h0000);
        check("rst_err", resp_err, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        reset = 1'b0;
        tick();

        // Word store 0x1234 to 0x0008, stepped cycle by cycle
        req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0008; req_wdata = 16'h1234;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("ws_t1_mem_write", mem_write, 1'b1);
        check("ws_t1_mem_addr", mem_addr, 16'h0008);
        check("ws_t1_mem_wdata", mem_wdata, 16'h1234);
        check("ws_t1_resp_valid", resp_valid, 1'b0);
        tick();
        check("ws_t2_resp_valid", resp_valid, 1'b1);
        check("ws_t2_mem_write", mem_write, 1'b0);
        check("ws_t2_rdata", resp_rdata, 16'h0000);
        tick();
        check("ws_idle", req_ready, 1'b1);
        check("ws_wr_cnt", wr_cnt, 1);
        check("ws_mem", mem[2], 16'h1234);

        // Word load back
        do_req("wl", 1'b0, 1'b0, 16'h0008, 16'h0000, 2, 16'h1234, 1'b0);

        // Byte store 0x5C to upper lane of word holding 0xAABB
        req_write = 1'b1; req_byte = 1'b1; req_addr = 16'h0005; req_wdata = 16'hFF5C;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("bs_t1_mem_write", mem_write, 1'b0);
        tick();
        check("bs_t2_mem_write", mem_write, 1'b1);
        check("bs_t2_mem_wdata", mem_wdata, 16'h5CBB);
        check("bs_t2_resp_valid", resp_valid, 1'b0);
        tick();
        check("bs_t3_resp_valid", resp_valid, 1'b1);
        check("bs_t3_rdata", resp_rdata, 16'h0000);
        tick();
        check("bs_mem", mem[1], 16'h5CBB);
        check("bs_wr_cnt", wr_cnt, 2);

        // Byte store to lower lane of word 0x1234 at 0x0008
        do_req("bs_lo", 1'b1, 1'b1, 16'h0008, 16'h0077, 3, 16'h0000, 1'b0);
        check("bs_lo_mem", mem[2], 16'h1277);

        // Byte loads of both lanes
        do_req("bl_lo", 1'b0, 1'b1, 16'h0004, 16'h0000, 2, 16'h00BB, 1'b0);
        do_req("bl_hi", 1'b0, 1'b1, 16'h0005, 16'h0000, 2, 16'h005C, 1'b0);

        // Backpressure with a competing store request held during RESP
        resp_ready = 1'b0;
        wr_before = wr_cnt;
        req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0008; req_wdata = 16'h0000;
        req_valid = 1'b1;
        tick();
        req_write = 1'b1; req_addr = 16'h0004; req_wdata = 16'hDEAD;
        tick();
        check("bp_resp_valid0", resp_valid, 1'b1);
        check("bp_rdata0", resp_rdata, 16'h1277);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_rdata", resp_rdata, 16'h1277);
            check("bp_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("bp_release_ready", req_ready, 1'b1);
        check("bp_resp_gone", resp_valid, 1'b0);
        check("bp_no_write", wr_cnt, wr_before);
        check("bp_mem", mem[1], 16'h5CBB);

        // Reset asserted during RMW_WR
        wr_before = wr_cnt;
        req_write = 1'b1; req_byte = 1'b1; req_addr = 16'h0004; req_wdata = 16'h0011;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("rr_in_rmw_wr", mem_write, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("rr_mem_write", mem_write, 1'b0);
        check("rr_req_ready", req_ready, 1'b1);
        check("rr_resp_valid", resp_valid, 1'b0);
        check("rr_mem_addr", mem_addr, 16'h0000);
        check("rr_mem_wdata", mem_wdata, 16'h0000);
        check("rr_rdata", resp_rdata, 16'h0000);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("rr_no_resp", resp_valid, 1'b0);
        check("rr_mem", mem[1], 16'h5CBB);
        check("rr_wr_cnt", wr_cnt, wr_before);

`ifdef LSU_ALIGN_CHECK_EN
        wr_before = wr_cnt;
        do_req("al_unaligned", 1'b0, 1'b0, 16'h0006, 16'h0000, 1, 16'h0000, 1'b1);
        do_req("al_range", 1'b1, 1'b0, 16'h0080, 16'hBEEF, 1, 16'h0000, 1'b1);
        check("al_no_write", wr_cnt, wr_before);
        check("al_mem0", mem[0], 16'h0000);
`else
        do_req("na_unaligned", 1'b0, 1'b0, 16'h0006, 16'h0000, 2, 16'h5CBB, 1'b0);
        do_req("na_alias", 1'b1, 1'b0, 16'h0080, 16'hBEEF, 2, 16'h0000, 1'b0);
        check("na_alias_mem0", mem[0], 16'hBEEF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the 16-bit RISC core: the initiator side of the data-memory interface. It accepts one load or store request at a time from the execute stage, drives the data memory's `memWrite`/`addr`/`writeData` inputs and captures its `readData`, then returns a response. Byte stores are done as read-modify-write because the data memory has no byte enables.

## Interface
- `n`, default 16: data and address width in bits.
- `r`, default 5: log2 of data-memory depth in words. Must match the data memory's `r`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = word access.
- `req_addr`  in  n  byte address.
- `req_wdata`  in  n  store data; byte stores use `[7:0]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  n  load data; 0 for stores.
- `resp_err`  out  1  access rejected (see Configuration).
- `mem_write`  out  1  to the data memory's `memWrite`.
- `mem_addr`  out  n  to the data memory's `addr`.
- `mem_wdata`  out  n  to the data memory's `writeData`.
- `mem_rdata`  in  n  from the data memory's `readData`. Combinational read of `mem_addr`.

## Operation
- **Memory word index.** The word index is `addr[n-1:2]`. Bits `[1:0]` never reach the memory.
- **Byte lane.** `addr[0]` selects the byte: 0 → `[7:0]`, 1 → `[15:8]`. `addr[1]` is ignored.
- **Request latch.** On accept (`req_valid && req_ready`), the unit latches `req_addr`, `req_wdata`, `req_write` and `req_byte`.
  - `mem_addr` is always the latched address.
  - `mem_wdata` is the latched data, or the merged word in RMW_WR.
- **FSM states:** IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- **IDLE**
  - `req_ready`=1; all other outputs are idle.
  - On accept: load → LOAD; word store → STORE; byte store → RMW_RD.
- **LOAD**
  - Capture `mem_rdata` into `resp_rdata`, then go to RESP.
  - Word load: the full word.
  - Byte load: the selected byte, zero-extended to n bits.
- **STORE:** `mem_write`=1 for exactly this cycle, with the latched data. Then RESP.
- **RMW_RD:** capture `mem_rdata` into the merge register. Then RMW_WR.
- **RMW_WR**
  - `mem_write`=1 with the merge word; the selected byte is replaced by `wdata[7:0]` and the other byte is preserved.
  - Then RESP.
- **RESP**
  - `resp_valid`=1; `resp_rdata` and `resp_err` stay stable.
  - On `resp_ready`, go to IDLE.
  - `resp_rdata`=0 after stores.
- `req_ready` is high only in IDLE, so there is never more than one outstanding request.
- `mem_write` is decoded from the state only; it is high solely in STORE and RMW_WR.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- **Latency.** With the accept edge at cycle T:
  - load or word store: `resp_valid` rises at T+2;
  - byte store: `resp_valid` rises at T+3.
- **RESP exit.** If `resp_ready` is already high when RESP is entered, RESP lasts one cycle. IDLE follows, and `req_ready` is high on the next cycle.
- **Best-case throughput:** one request per 3 cycles for loads and word stores, one per 4 for byte stores.
- **Request presented during RESP.** `req_valid` asserted during RESP is not accepted. The requester must hold it until `req_ready` is high.
- **Reset mid-operation.** Asynchronous reset in any state forces IDLE immediately:
  - `mem_write` drops in the same cycle;
  - the pending transaction is dropped and no response is produced;
  - a partially completed RMW leaves memory unmodified.

## Configuration
- **Macro:** `LSU_ALIGN_CHECK_EN`.
- **Defined.** A request is rejected if any of the following holds:
  - it is a word access with `addr[1:0]`≠0;
  - it is a byte access with `addr[1]`≠0;
  - `addr[n-1:r+2]`≠0 (beyond memory depth).
- **Rejected request handling:**
  - IDLE goes straight to RESP and raises `resp_err`=1 with `resp_rdata`=0;
  - `mem_write` is never asserted;
  - response latency is T+1.
- **Undefined.**
  - No checks are made and `resp_err` is tied to 0.
  - Out-of-range or unaligned addresses alias per the word-index and byte-lane rules in Operation.

## Test plan
- **Word store, then load.** Store word 0x1234 to addr 0x0008, then load word from 0x0008.
  - Exactly one `mem_write` pulse occurs, with `mem_addr`=0x0008 and `mem_wdata`=0x1234.
  - The load returns `resp_rdata`=0x1234 at T+2.
- **Byte store, upper lane.** Memory word at 0x0004 holds 0xAABB. Store byte 0x5C to addr 0x0005.
  - RMW writes 0x5CBB with one `mem_write` pulse at T+2.
  - `resp_valid` rises at T+3.
- **Byte load.** Load byte from 0x0004 with the word holding 0x5CBB → `resp_rdata`=0x00BB. Load byte from 0x0005 → 0x005C.
- **Backpressure.** Hold `resp_ready`=0 for 4 cycles after a load.
  - `resp_valid` and `resp_rdata` stay stable, `req_ready` stays 0, and a concurrent `req_valid` is ignored.
  - After `resp_ready` rises, `req_ready`=1 on the next cycle.
- **Reset mid-RMW.** Assert `reset` during RMW_WR.
  - `mem_write` goes low immediately, no `resp_valid` is produced, and all outputs take their reset values.
- **With `LSU_ALIGN_CHECK_EN` defined:**
  - word load at 0x0006 → `resp_err`=1, `resp_rdata`=0, response at T+1, no `mem_write`;
  - word store at 0x0080 (beyond 32 words) → `resp_err`=1 and memory unchanged.
- **Without `LSU_ALIGN_CHECK_EN`:** word load at 0x0006 → reads word index 1, `resp_err`=0.
